// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : key_conditioner
// Purpose  : Conditions four raw lane keys for the rhythm-game control logic.
//            Each lane has a metastability synchronizer, a counter-based
//            debouncer, one-cycle press/release pulses and a saturating
//            hold-time counter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEBOUNCE_CYCLES : stable cycles needed to accept a level change (1..2^20-1)
//   SYNC_STAGES     : synchronizer depth (2..4)
//   HOLD_W          : width of each hold counter
// Ports
//   clk         in   1          game clock, rising edge
//   rst         in   1          asynchronous active-high reset
//   key_raw     in   4          raw key pins, 1 = pressed, bit i = lane i
//   key_level   out  4          debounced key state
//   key_press   out  4          one-cycle pulse on debounced rising edge
//   key_release out  4          one-cycle pulse on debounced falling edge
//   hold_cnt    out  4*HOLD_W   lane i at [i*HOLD_W +: HOLD_W]
// Configuration
//   KEY_HOLD_CNT_EN : when defined the hold counters are built; otherwise
//                     hold_cnt is tied to zero.
// ============================================================================
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            key_raw,
    output logic [3:0]            key_level,
    output logic [3:0]            key_press,
    output logic [3:0]            key_release,
    output logic [4*HOLD_W-1:0]   hold_cnt
);

    localparam logic [19:0] c_DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [SYNC_STAGES-1:0] r_sync;
        logic [19:0]            r_db_cnt;
        logic                   r_level;
        logic                   r_press;
        logic                   r_release;
        logic                   w_sync;
        logic                   w_level_next;
        logic [19:0]            w_cnt_next;

        assign w_sync = r_sync[SYNC_STAGES-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], key_raw[i]};
            end
        end

        // Counter restarts whenever the synchronized input agrees with the
        // accepted level, so any bounce back restarts the stability window.
        always_comb begin
            w_level_next = r_level;
            w_cnt_next   = '0;
            if (w_sync != r_level) begin
                if (r_db_cnt == c_DB_LAST) begin
                    w_level_next = w_sync;
                end else begin
                    w_cnt_next = r_db_cnt + 20'd1;
                end
            end
        end

        // Pulses are derived from the next level so they line up with the
        // first cycle the new level is visible on key_level.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_db_cnt  <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_db_cnt  <= w_cnt_next;
                r_level   <= w_level_next;
                r_press   <= w_level_next & ~r_level;
                r_release <= ~w_level_next & r_level;
            end
        end

        assign key_level[i]   = r_level;
        assign key_press[i]   = r_press;
        assign key_release[i] = r_release;

`ifdef KEY_HOLD_CNT_EN
        logic [HOLD_W-1:0] r_hold;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_hold <= '0;
            end else if (!w_level_next) begin
                r_hold <= '0;
            end else if (r_hold != {HOLD_W{1'b1}}) begin
                r_hold <= r_hold + 1'b1;
            end
        end

        assign hold_cnt[i*HOLD_W +: HOLD_W] = r_hold;
`else
        assign hold_cnt[i*HOLD_W +: HOLD_W] = '0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_conditioner
// Purpose  : Self-checking bench for key_conditioner (DEBOUNCE_CYCLES=4,
//            SYNC_STAGES=2, HOLD_W=4). A window-based reference model tracks
//            the expected outputs; directed steps cover reset, latency,
//            bounce, simultaneous lanes, saturation and reset mid-press,
//            followed by randomized key activity. Honors KEY_HOLD_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_conditioner;

    localparam int D  = 4;
    localparam int S  = 2;
    localparam int HW = 4;
    localparam int HMAX = (1 << HW) - 1;

    logic            clk;
    logic            rst;
    logic [3:0]      key_raw;
    logic [3:0]      key_level;
    logic [3:0]      key_press;
    logic [3:0]      key_release;
    logic [4*HW-1:0] hold_cnt;

    int errors = 0;
    int checks = 0;

    key_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (S),
        .HOLD_W          (HW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .hold_cnt    (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // pipe holds the last S raw samples (oldest first): the oldest is what the
    // debouncer sees this edge. win holds the last D debouncer inputs; a lane
    // flips when all D of them disagree with its current level.
    logic [3:0] pipe[$];
    logic [3:0] win[$];
    logic [3:0] m_level, m_press, m_release;
    int         m_hold[4];

    always @(posedge clk or posedge rst) begin : model
        logic [3:0] sin;
        logic [3:0] nxt;
        logic       flip;
        if (rst) begin
            pipe = {};
            win  = {};
            for (int k = 0; k < S; k++) pipe.push_back(4'b0);
            for (int k = 0; k < D; k++) win.push_back(4'b0);
            m_level   = '0;
            m_press   = '0;
            m_release = '0;
            for (int l = 0; l < 4; l++) m_hold[l] = 0;
        end else begin
            sin = pipe.pop_front();
            pipe.push_back(key_raw);
            win.push_back(sin);
            void'(win.pop_front());
            nxt = m_level;
            for (int l = 0; l < 4; l++) begin
                flip = 1'b1;
                for (int k = 0; k < D; k++)
                    if (win[k][l] == m_level[l]) flip = 1'b0;
                if (flip) nxt[l] = ~m_level[l];
            end
            m_press   = nxt & ~m_level;
            m_release = ~nxt & m_level;
            for (int l = 0; l < 4; l++)
                m_hold[l] = nxt[l] ? ((m_hold[l] + 1 > HMAX) ? HMAX : m_hold[l] + 1) : 0;
            m_level = nxt;
        end
    end

    function automatic logic [4*HW-1:0] exp_hold();
        logic [4*HW-1:0] v;
        v = '0;
`ifdef KEY_HOLD_CNT_EN
        for (int l = 0; l < 4; l++) v[l*HW +: HW] = m_hold[l][HW-1:0];
`endif
        return v;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("level",   {28'b0, key_level},   {28'b0, m_level});
        chk("press",   {28'b0, key_press},   {28'b0, m_press});
        chk("release", {28'b0, key_release}, {28'b0, m_release});
        chk("hold",    {16'b0, hold_cnt},    {16'b0, exp_hold()});
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"},   {28'b0, key_level},   32'h0);
        chk({tag, "_press"},   {28'b0, key_press},   32'h0);
        chk({tag, "_release"}, {28'b0, key_release}, 32'h0);
        chk({tag, "_hold"},    {16'b0, hold_cnt},    32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int np, nr, nl;
        logic [3:0] r;
        static logic [0:29] bounce = 30'b111011100000011110000000000000;

        rst     = 1'b1;
        key_raw = 4'hF;

        // 1. reset with keys held, then release with keys still held
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("t1_press", {28'b0, key_press}, (c == 5) ? 32'hF : 32'h0);
        end
        key_raw = 4'h0;
        repeat (10) tick();

        // 2. clean press and release on lane 0
        key_raw = 4'h1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t2_press0", {31'b0, key_press[0]}, (c == 5) ? 32'h1 : 32'h0);
            chk("t2_level0", {31'b0, key_level[0]}, (c >= 5) ? 32'h1 : 32'h0);
`ifdef KEY_HOLD_CNT_EN
            chk("t2_hold0", {28'b0, hold_cnt[3:0]}, (c >= 5) ? 32'(c - 4) : 32'h0);
`else
            chk("t2_hold0", {28'b0, hold_cnt[3:0]}, 32'h0);
`endif
        end
        key_raw = 4'h0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t2_release0", {31'b0, key_release[0]}, (c == 5) ? 32'h1 : 32'h0);
            if (c == 5) chk("t2_hold0_rel", {28'b0, hold_cnt[3:0]}, 32'h0);
        end

        // 3. bounce rejection on lane 2, then a qualifying 4-cycle hold
        np = 0; nr = 0; nl = 0;
        for (int c = 0; c < 30; c++) begin
            key_raw = {1'b0, bounce[c], 2'b00};
            tick();
            if (key_press[2])   np++;
            if (key_release[2]) nr++;
            if (c < 14 && key_level[2]) nl++;
        end
        chk("t3_level_during_bounce", nl, 0);
        chk("t3_press_count", np, 1);
        chk("t3_release_count", nr, 1);

        // 4. simultaneous press on lanes 1 and 3
        key_raw = 4'b1010;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("t4_press", {28'b0, key_press}, (c == 5) ? 32'hA : 32'h0);
        end
        key_raw = 4'h0;
        repeat (8) tick();

        // 5. saturation on lane 3
        key_raw = 4'h8;
        repeat (30) tick();
`ifdef KEY_HOLD_CNT_EN
        chk("t5_hold_sat", {28'b0, hold_cnt[15:12]}, 32'hF);
`else
        chk("t5_hold_sat", {28'b0, hold_cnt[15:12]}, 32'h0);
`endif
        key_raw = 4'h0;
        repeat (6) tick();
        chk("t5_hold_rel", {28'b0, hold_cnt[15:12]}, 32'h0);

        // reset mid-press: outputs clear at once, fresh press after release
        key_raw = 4'hF;
        repeat (8) tick();
        #2 rst = 1'b1;
        #1 chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("midrst_press", {28'b0, key_press}, (c == 5) ? 32'hF : 32'h0);
            chk("midrst_release", {28'b0, key_release}, 32'h0);
        end

        // randomized key activity, with one asynchronous reset in the middle
        r = key_raw;
        for (int c = 0; c < 600; c++) begin
            for (int l = 0; l < 4; l++)
                if ($urandom_range(5) == 0) r[l] = ~r[l];
            key_raw = r;
            if (c == 300) begin
                #3 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
